apb_sram_inf: RTL and testbench
===============================

// Module: apb_sram_inf
// PURPOSE
//  APB3 slave bridging a single APB port to an on-chip single-port synchronous SRAM
//  (1024 x 32). Zero-wait-state writes and reads; one transfer per setup+access phase pair.
//  Sits behind the APB decoder as a scratch/config memory.
// PARAMETERS
//  ADDR_W  10  word-address width; depth = 2**ADDR_W words
//  DATA_W  32  data width
// PORTS
//  clk      in   1       system clock; all logic on rising edge
//  rstn     in   1       reset; synchronous, active-high (asserted when rstn==1)
//  psel     in   1       APB slave select
//  penable  in   1       APB access-phase strobe
//  paddr    in   ADDR_W  word address (no byte offset; full decode, no out-of-range)
//  pwrite   in   1       1 = write, 0 = read
//  pwdata   in   DATA_W  write data
//  pready   out  1       transfer complete
//  prdata   out  DATA_W  read data
// BEHAVIOUR
//  Reset (rstn==1 at rising edge): prdata <= 0; SRAM port idle; no write occurs.
//   Memory contents are NOT reset. pready forced 0 while rstn==1.
//  Phases: IDLE (!psel), SETUP (psel & !penable), ACCESS (psel & penable).
//  pready: combinational = psel & penable & !rstn; no wait states ever inserted.
//  Write: SRAM written at the rising edge ending ACCESS with pwrite==1:
//   mem[paddr] <= pwdata. Exactly one write per ACCESS edge.
//  Read: SRAM read enable issued in SETUP with pwrite==0 (addr = paddr); SRAM data
//   registered at that edge; prdata valid for the whole ACCESS phase (latency 1 clk
//   from SETUP). prdata holds its last value outside read transfers.
//  Write-then-read same address: read in a later SETUP returns the newly written data.
//  penable without psel: ignored (no write, no read, pready=0).
//  psel held with penable held across edges: each edge in ACCESS with pwrite=1 rewrites
//   the same word (idempotent); reads keep prdata updated from SETUP capture only.
//  paddr wider values driven by upstream are truncated to ADDR_W (e.g. 12'hFF1 -> 10'h3F1).
//  Reset mid-transfer: transfer aborted; a write whose ACCESS edge sees rstn==1 is dropped.
//  Implemented as a small 3-state FSM (IDLE/SETUP/ACCESS) tracking phase for enable gen;
//   illegal state recovers to IDLE.
// STRUCTURE
//  Package apb_sram_pkg: ADDR_W, DATA_W, phase enum {IDLE, SETUP, ACCESS}.
//  Sub-module sram_sp_1024x32: single-port sync SRAM (ce, we, addr, wdata, rdata),
//   registered read, no reset on array; apb_sram_inf holds FSM, enable decode, prdata reg.
// TESTING
//  1 Reset: rstn=1 two clks -> prdata==0, pready==0; release rstn=0.
//  2 Write 0x3F1<-0xFFFF_FF01 (SETUP then ACCESS), then read 0x3F1 -> prdata==0xFFFF_FF01
//    during ACCESS, pready==1 in each ACCESS.
//  3 Writes 0x000<-0xA5A5_0001, 0x3FF<-0x5A5A_03FF, back-to-back; read both -> exact
//    values, no aliasing between boundary words.
//  4 penable=1 with psel=0, pwrite=1, pwdata=0xDEAD_BEEF at 0x3F1 -> later read still
//    0xFFFF_FF01; pready stays 0.
//  5 Assert rstn during ACCESS of write 0x010<-0x1234_5678 -> read 0x010 afterwards
//    returns prior contents (write dropped), prdata==0 right after reset.
//  6 Paddr 12'hFF1 driven via truncation -> same word as 0x3F1.

Source files
------------

// File: rtl/apb_sram_pkg.sv
// rtl/apb_sram_pkg.sv - shared widths and APB phase encoding for the APB SRAM bridge
package apb_sram_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_t;

  // Phase implied by the bus strobes in the current cycle.
  function automatic apb_phase_t phase_of(input logic sel, input logic enable);
    if (!sel) begin
      return IDLE;
    end else if (!enable) begin
      return SETUP;
    end
    return ACCESS;
  endfunction

endpackage

// File: rtl/sram_sp_1024x32.sv
// rtl/sram_sp_1024x32.sv - single-port synchronous SRAM with registered read
module sram_sp_1024x32
  import apb_sram_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  // Array and read register are deliberately unreset, like a hard macro.
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/apb_sram_inf.sv
// rtl/apb_sram_inf.sv - zero-wait-state APB3 slave in front of a 1024x32 SRAM
module apb_sram_inf
  import apb_sram_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          psel,
  input  logic          penable,
  input  logic [AW-1:0] paddr,
  input  logic          pwrite,
  input  logic [DW-1:0] pwdata,
  output logic          pready,
  output logic [DW-1:0] prdata
);

  apb_phase_t    state, state_nxt;
  apb_phase_t    bus_phase;
  logic          rd_issue;
  logic          wr_issue;
  logic          sram_ce;
  logic          rd_seen;
  logic [DW-1:0] sram_rdata;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A write is only honoured once the bus has been selected for at least one
  // prior edge, so a stray access strobe straight out of IDLE cannot corrupt memory.
  always_comb begin
    state_nxt = IDLE;
    bus_phase = phase_of(psel, penable);
    rd_issue  = 1'b0;
    wr_issue  = 1'b0;
    case (state)
      IDLE, SETUP, ACCESS: state_nxt = bus_phase;
      default:             state_nxt = IDLE;
    endcase
    if (!rstn) begin
      rd_issue = (bus_phase == SETUP) && !pwrite;
      wr_issue = (bus_phase == ACCESS) && pwrite &&
                 ((state == SETUP) || (state == ACCESS));
    end
  end

  assign sram_ce = rd_issue | wr_issue;

  sram_sp_1024x32 #(
    .AW (AW),
    .DW (DW)
  ) u_sram (
    .clk   (clk),
    .ce    (sram_ce),
    .we    (wr_issue),
    .addr  (paddr),
    .wdata (pwdata),
    .rdata (sram_rdata)
  );

  // The SRAM read register only moves on a read, so it already holds the last
  // read value; rd_seen masks its unreset contents until the first read.
  always_ff @(posedge clk) begin
    if (rstn) begin
      rd_seen <= 1'b0;
    end else if (rd_issue) begin
      rd_seen <= 1'b1;
    end
  end

  assign prdata = rd_seen ? sram_rdata : '0;
  assign pready = psel & penable & ~rstn;

endmodule

// File: tb/tb_apb_sram_inf.sv
// tb/tb_apb_sram_inf.sv - directed self-checking bench for apb_sram_inf
module tb_apb_sram_inf;

  logic        clk;
  logic        rstn;
  logic        psel;
  logic        penable;
  logic [9:0]  paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;

  int tests_run;
  int tests_failed;

  apb_sram_inf dut (
    .clk     (clk),
    .rstn    (rstn),
    .psel    (psel),
    .penable (penable),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .pready  (pready),
    .prdata  (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [9:0] addr, input logic [31:0] data, input string tag);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check({tag, "_pready"}, {31'd0, pready}, 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [9:0] addr, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check({tag, "_pready"}, {31'd0, pready}, 32'd1);
    check({tag, "_prdata"}, prdata, exp);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [11:0] wide_addr;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstn = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;

    // 1: reset
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset_prdata", prdata, 32'h0);
    check("reset_pready", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b0;

    // 2: write then read top-region word
    apb_write(10'h3F1, 32'hFFFF_FF01, "wr_3f1");
    apb_read (10'h3F1, 32'hFFFF_FF01, "rd_3f1");

    // 3: boundary words, no aliasing
    apb_write(10'h000, 32'hA5A5_0001, "wr_000");
    apb_write(10'h3FF, 32'h5A5A_03FF, "wr_3ff");
    apb_read (10'h000, 32'hA5A5_0001, "rd_000");
    apb_read (10'h3FF, 32'h5A5A_03FF, "rd_3ff");

    // 4: penable without psel is ignored
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 10'h3F1; pwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("nosel_pready", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("nosel_pready2", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    penable = 1'b0; pwrite = 1'b0;
    apb_read(10'h3F1, 32'hFFFF_FF01, "rd_3f1_after_nosel");

    // 5: reset during ACCESS drops the write
    apb_write(10'h010, 32'h0BAD_0010, "wr_010");
    apb_read (10'h010, 32'h0BAD_0010, "rd_010");
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h010; pwdata = 32'h1234_5678;
    @(posedge clk); #1;
    penable = 1'b1; rstn = 1'b1;
    @(negedge clk);
    check("abort_pready", {31'd0, pready}, 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    check("abort_prdata", prdata, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b0;
    apb_read(10'h010, 32'h0BAD_0010, "rd_010_after_abort");

    // 6: upstream 12-bit address truncates onto the same word
    wide_addr = 12'hFF1;
    apb_read(wide_addr[9:0], 32'hFFFF_FF01, "rd_ff1_trunc");
    apb_write(wide_addr[9:0], 32'h0C0F_FEE1, "wr_ff1_trunc");
    apb_read(10'h3F1, 32'h0C0F_FEE1, "rd_3f1_via_trunc");

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
